// File: rtl/serial_popcount_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_popcount_pkg
//  Description : Shared FSM state encoding and count-width helper for the
//                serial popcount producer and its downstream consumer.
//  Revision    : 1.0 - initial release
// ============================================================================
package serial_popcount_pkg;

  // FSM states, explicit 2-bit encoding
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Bits needed to hold a set-bit count of a w-bit word (0..w inclusive).
  // Consumers call this too so both ends agree on the operand width.
  function automatic int count_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/popcount_chunk.sv
`default_nettype none
// ============================================================================
//  Module      : popcount_chunk
//  Description : Combinational set-bit count of a small WIDTH-bit slice.
//  Revision    : 1.0 - initial release
// ============================================================================
module popcount_chunk
  import serial_popcount_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0]                bits_i,
  output logic [count_width(WIDTH)-1:0]   count_o
);

  localparam int PW = count_width(WIDTH);

  // Sum the bits of the slice, each zero-extended to the result width
  always_comb begin
    count_o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      count_o = count_o + PW'(bits_i[i]);
    end
  end

endmodule
`default_nettype wire

// File: rtl/serial_popcount.sv
`default_nettype none
// ============================================================================
//  Module      : serial_popcount
//  Description : Counts set bits of an accepted DATA_WIDTH word, examining
//                BITS_PER_CYCLE bits per clock, and offers the count on a
//                valid/ready output. One word in flight at a time.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_popcount
  import serial_popcount_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [DATA_WIDTH-1:0]               in_data,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [count_width(DATA_WIDTH)-1:0]  out_count,
  output logic                                busy
);

  localparam int N  = (BITS_PER_CYCLE > 0) ? DATA_WIDTH / BITS_PER_CYCLE : 1;
  localparam int CW = count_width(DATA_WIDTH);
  localparam int PW = count_width(BITS_PER_CYCLE);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  generate
    if (DATA_WIDTH < 1 || BITS_PER_CYCLE < 1 ||
        (DATA_WIDTH % BITS_PER_CYCLE) != 0) begin : g_param_check
      $error("serial_popcount: DATA_WIDTH must be >= 1 and a multiple of BITS_PER_CYCLE");
    end
  endgenerate

  state_e                  state_q;
  logic [DATA_WIDTH-1:0]   shreg_q;
  logic [DATA_WIDTH-1:0]   shreg_d;
  logic [IW-1:0]           idx_q;
  logic [CW-1:0]           acc_q;
  logic [CW-1:0]           acc_d;
  logic [PW-1:0]           chunk_cnt;

  // Count of the chunk currently sitting in the low bits of the shift register
  popcount_chunk #(
    .WIDTH (BITS_PER_CYCLE)
  ) u_chunk (
    .bits_i  (shreg_q[BITS_PER_CYCLE-1:0]),
    .count_o (chunk_cnt)
  );

  // Next accumulator and shift-register values for one COUNT step
  always_comb begin
    acc_d   = acc_q + CW'(chunk_cnt);
    shreg_d = shreg_q >> BITS_PER_CYCLE;
  end

  // Control FSM plus datapath registers; partial count is dropped on reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      idx_q   <= '0;
      acc_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            shreg_q <= in_data;
            acc_q   <= '0;
            idx_q   <= '0;
            state_q <= COUNT;
          end
        end
        COUNT: begin
          acc_q   <= acc_d;
          shreg_q <= shreg_d;
          idx_q   <= idx_q + IW'(1);
          if (idx_q == LAST_IDX) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Handshake flags come straight from the state register, no input paths
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_count = acc_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_popcount.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_serial_popcount
//  Description : Scoreboard bench over four configurations:
//                0: DW=8 BPC=1, 1: DW=8 BPC=4, 2: DW=1 BPC=1, 3: DW=12 BPC=3
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_popcount;

  localparam int NLAT [4] = '{8, 2, 1, 4};

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  ivld;
  logic [3:0]  irdy;
  logic [3:0]  ovld;
  logic [3:0]  ordy;
  logic [3:0]  rdy;
  logic [3:0]  bsy;
  logic [31:0] idata [4];
  logic [31:0] oc    [4];
  logic [3:0]  oc0, oc1, oc3;
  logic [0:0]  oc2;
  logic        rnd_on;
  logic        rnd_bit;

  int          cyc = 0;
  int          passed = 0;
  int          total = 0;
  int          exp_q [4][$];
  int          acc_edge [4];
  logic [3:0]  acc_prev, xfer_prev, vld_prev;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign rdy   = {rnd_on ? rnd_bit : ordy[3], ordy[2:0]};
  assign oc[0] = {28'd0, oc0};
  assign oc[1] = {28'd0, oc1};
  assign oc[2] = {31'd0, oc2};
  assign oc[3] = {28'd0, oc3};

  serial_popcount #(.DATA_WIDTH(8), .BITS_PER_CYCLE(1)) u_d8 (
    .clk(clk), .rst(rst), .in_valid(ivld[0]), .in_ready(irdy[0]),
    .in_data(idata[0][7:0]), .out_valid(ovld[0]), .out_ready(rdy[0]),
    .out_count(oc0), .busy(bsy[0]));

  serial_popcount #(.DATA_WIDTH(8), .BITS_PER_CYCLE(4)) u_b4 (
    .clk(clk), .rst(rst), .in_valid(ivld[1]), .in_ready(irdy[1]),
    .in_data(idata[1][7:0]), .out_valid(ovld[1]), .out_ready(rdy[1]),
    .out_count(oc1), .busy(bsy[1]));

  serial_popcount #(.DATA_WIDTH(1), .BITS_PER_CYCLE(1)) u_w1 (
    .clk(clk), .rst(rst), .in_valid(ivld[2]), .in_ready(irdy[2]),
    .in_data(idata[2][0:0]), .out_valid(ovld[2]), .out_ready(rdy[2]),
    .out_count(oc2), .busy(bsy[2]));

  serial_popcount #(.DATA_WIDTH(12), .BITS_PER_CYCLE(3)) u_r12 (
    .clk(clk), .rst(rst), .in_valid(ivld[3]), .in_ready(irdy[3]),
    .in_data(idata[3][11:0]), .out_valid(ovld[3]), .out_ready(rdy[3]),
    .out_count(oc3), .busy(bsy[3]));

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: handshake sequencing, latency and result against the scoreboard
  always @(negedge clk) begin
    if (rst) begin
      acc_prev  = '0;
      xfer_prev = '0;
      vld_prev  = '0;
      for (int i = 0; i < 4; i++) exp_q[i].delete();
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (acc_prev[i]) begin
          chk($sformatf("u%0d_in_ready_after_accept", i), int'(irdy[i]), 0);
          chk($sformatf("u%0d_busy_after_accept", i), int'(bsy[i]), 1);
        end
        if (xfer_prev[i]) begin
          chk($sformatf("u%0d_in_ready_after_xfer", i), int'(irdy[i]), 1);
          chk($sformatf("u%0d_out_valid_after_xfer", i), int'(ovld[i]), 0);
        end
        if (ovld[i]) begin
          chk($sformatf("u%0d_output_expected", i), int'(exp_q[i].size() != 0), 1);
          if (exp_q[i].size() != 0) begin
            if (!vld_prev[i])
              chk($sformatf("u%0d_latency", i), cyc - acc_edge[i], NLAT[i]);
            chk($sformatf("u%0d_out_count", i), oc[i], exp_q[i][0]);
            if (rdy[i]) void'(exp_q[i].pop_front());
          end
        end
        acc_prev[i]  = ivld[i] && irdy[i];
        if (acc_prev[i]) acc_edge[i] = cyc + 1;
        xfer_prev[i] = ovld[i] && rdy[i];
        vld_prev[i]  = ovld[i];
      end
    end
  end

  // Present a word, wait (bounded) for it to be taken, push the expectation
  task automatic send(input int i, input logic [31:0] d, input int e);
    int n;
    @(posedge clk); #1;
    idata[i] = d;
    ivld[i]  = 1'b1;
    n = 0;
    @(negedge clk);
    while (!irdy[i] && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("u%0d_accept_timeout", i), int'(irdy[i]), 1);
    exp_q[i].push_back(e);
    @(posedge clk); #1;
    ivld[i] = 1'b0;
  endtask

  task automatic wait_empty(input int i, input int bound);
    int n;
    n = 0;
    while (exp_q[i].size() != 0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("u%0d_drain_timeout", i), int'(exp_q[i].size() == 0), 1);
  endtask

  // Random backpressure source for the 12-bit instance
  initial begin
    rnd_bit = 1'b1;
    forever begin
      @(posedge clk); #1;
      rnd_bit = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    logic [31:0] d;
    rst    = 1'b1;
    ivld   = '0;
    ordy   = 4'hF;
    rnd_on = 1'b0;
    for (int i = 0; i < 4; i++) idata[i] = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state of every instance
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("u%0d_rst_in_ready", i), int'(irdy[i]), 1);
      chk($sformatf("u%0d_rst_out_valid", i), int'(ovld[i]), 0);
      chk($sformatf("u%0d_rst_busy", i), int'(bsy[i]), 0);
      chk($sformatf("u%0d_rst_out_count", i), oc[i], 0);
    end

    // Basic word, then full-width and empty words
    send(0, 32'hB5, 5);
    wait_empty(0, 50);
    send(0, 32'hFF, 8);
    wait_empty(0, 50);
    send(0, 32'h00, 0);
    wait_empty(0, 50);

    // Backpressure with ignored input pulses while the result is held
    ordy[0] = 1'b0;
    send(0, 32'h0F, 4);
    n = 0;
    while (!ovld[0] && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("bp_valid_seen", int'(ovld[0]), 1);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      ivld[0]  = k[0];
      idata[0] = 32'hFF;
      @(negedge clk);
      chk("bp_valid_hold", int'(ovld[0]), 1);
      chk("bp_count_hold", oc[0], 4);
      chk("bp_in_ready_low", int'(irdy[0]), 0);
    end
    @(posedge clk); #1;
    ivld[0] = 1'b0;
    ordy[0] = 1'b1;
    wait_empty(0, 50);

    // Reset in the third COUNT cycle discards the partial result
    send(0, 32'hAA, 4);
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready", int'(irdy[0]), 1);
    chk("midrst_out_valid", int'(ovld[0]), 0);
    chk("midrst_busy", int'(bsy[0]), 0);
    chk("midrst_out_count", oc[0], 0);
    send(0, 32'h01, 1);
    wait_empty(0, 50);

    // Four bits per cycle
    send(1, 32'hF3, 6);
    wait_empty(1, 50);
    send(1, 32'h5A, 4);
    wait_empty(1, 50);

    // Single-bit word
    send(2, 32'h1, 1);
    send(2, 32'h0, 0);
    wait_empty(2, 50);

    // 500 random 12-bit words under random backpressure
    rnd_on = 1'b1;
    for (int w = 0; w < 500; w++) begin
      d = $urandom & 32'hFFF;
      send(3, d, $countones(d));
    end
    wait_empty(3, 300);
    rnd_on = 1'b0;

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
